mem_arbiter: RTL
================

# mem_arbiter

Shares one slow memory port between the instruction cache and the data cache, so the chip can run with a single external memory instead of separate `memI`/`memD` ports. It sits between the two `cache` instances' memory-side interfaces and the memory. It serializes block reads and write-backs, granting one cache at a time and holding the grant until the memory returns `mem_ready`.

## Interface
- `ADDR_W`, default 28: block address width (byte address bits 31:4).
- `DATA_W`, default 128: block width.
- `D_PRIO`, default 0: 0 = round-robin between I and D; 1 = D-cache always wins ties.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_read`, `i_write` in 1 each: I-cache memory request.
- `i_addr` in ADDR_W: I-cache block address.
- `i_wdata` in DATA_W: I-cache write block.
- `i_rdata` out DATA_W: read block returned to the I-cache.
- `i_ready` out 1: transaction-done strobe to the I-cache.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: same as the I-side ports, for the D-cache.
- `mem_read`, `mem_write` out 1: request to memory.
- `mem_addr` out ADDR_W: address to memory.
- `mem_wdata` out DATA_W: write block to memory.
- `mem_rdata` in DATA_W: read block from memory.
- `mem_ready` in 1: memory-done strobe, one cycle high per transaction.

## Operation
- Requester protocol (cache side): a cache asserts read or write and holds addr/wdata stable until it samples its ready=1. It deasserts or changes the request on the edge where ready is seen.
- FSM states: `IDLE`, `GNT_I`, `GNT_D`. The register `last` (1 bit, I=0/D=1) records the most recently served requester.
- In `IDLE`:
  - No request: stay in `IDLE`.
  - One requester (read|write): grant it.
  - Both requesting, `D_PRIO=1`: grant D.
  - Both requesting, `D_PRIO=0`: grant the requester that is not `last`.
- On a grant edge, capture the winner's read, write, addr and wdata into the `mem_*` output registers, and enter `GNT_x`.
- In `GNT_x`:
  - `mem_*` outputs hold the captured values; later changes on the cache inputs are ignored.
  - On `mem_ready=1`: `x_ready=1` in the same cycle. At the next edge, clear `mem_read`/`mem_write`, set `last<=x`, and return to `IDLE`.
- `i_rdata` and `d_rdata` are both driven by `mem_rdata` (broadcast). Only the granted side's ready qualifies the data.
- `x_ready = mem_ready & (state==GNT_x)`. `mem_ready` seen in `IDLE` is ignored, and no ready is issued.
- A request with read and write both high is forwarded unchanged. Resolving it is the memory's concern; the arbiter does no checking.
- Reset:
  - Values: state `IDLE`, `last=0` (so the first tie goes to D), `mem_read=mem_write=0`, `mem_addr=0`, `mem_wdata=0`.
  - `i_ready` and `d_ready` are 0 throughout reset.
  - Reset mid-transaction abandons the transaction immediately. No ready is issued for it.

## Timing
- Grant latency: a request present in `IDLE` at edge T drives `mem_*` from T+1.
- Turnaround: `mem_ready` in cycle T gives `mem_read`=`mem_write`=0 in cycle T+1 (`IDLE`, one mandatory bubble). The next grant drives memory from T+2.
- Back-to-back write-back then read from the same cache: the cache re-requests in cycle T+1 and competes normally. Under round-robin, a pending other-side request wins first.
- Starvation bound (`D_PRIO=0`): a requester waits for at most one other transaction.
- `x_ready` and `x_rdata` are combinational from `mem_ready` and `mem_rdata`. All `mem_*` outputs are registered.

## Structure
- Shared package `mem_arb_pkg`:
  - Widths `ADDR_W=28`, `DATA_W=128`.
  - State encoding `IDLE=2'd0`, `GNT_I=2'd1`, `GNT_D=2'd2`.
  - Requester id constants `REQ_I=1'b0`, `REQ_D=1'b1`.
- Single module; no sub-module needed. The pick logic is a few lines inside it.

## Test plan
- Only I reads addr `28'h0000010`; memory asserts ready 4 cycles later with data `128'hA5..A5` -> `mem_read=1`, `mem_addr=28'h0000010` from T+1; `i_ready=1` with `i_rdata=A5..A5` in the ready cycle; `d_ready` stays 0; `mem_read=0` the next cycle.
- I and D request in the same cycle after reset, `D_PRIO=0` -> D served first (`last=0`). Then I is served, with `mem_addr` switching only after the one-cycle `IDLE` bubble.
- D write-back `28'h0000200`, `wdata=128'h1234`, followed by a D read, while I is continuously requesting -> order D-write, I-read, D-read; `mem_wdata=128'h1234` during the write.
- `D_PRIO=1`, both sides requesting continuously for 3 transactions -> D granted every time; I waits.
- `rst_n` pulsed low while in `GNT_I` with `mem_read=1` -> all `mem_*` outputs 0 immediately (asynchronous), state `IDLE`, no `i_ready`. A spurious `mem_ready` afterwards produces no ready.
- Granted cache changes `i_addr` mid-transaction -> `mem_addr` keeps the captured value until `mem_ready`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-cache memory arbiter: default widths, FSM
// state encoding and requester ids.
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache block transfers onto one memory port.
// The grant is held until mem_ready, and every mem_* output is registered.
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int D_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  import mem_arb_pkg::*;

  arb_state_e        state_q;
  logic              last_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic i_req;
  logic d_req;
  logic d_wins;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // On a tie D wins when it has fixed priority or when I was served last.
  assign d_wins = d_req & (~i_req | (D_PRIO != 0) | (last_q == REQ_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= REQ_I;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_wins) begin
            state_q     <= GNT_D;
            mem_read_q  <= d_read;
            mem_write_q <= d_write;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_req) begin
            state_q     <= GNT_I;
            mem_read_q  <= i_read;
            mem_write_q <= i_write;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= i_wdata;
          end
        end
        GNT_I, GNT_D: begin
          // Address and data stay put after completion; only the strobes drop.
          if (mem_ready) begin
            state_q     <= IDLE;
            last_q      <= (state_q == GNT_D) ? REQ_D : REQ_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_ready = mem_ready & (state_q == GNT_I);
  assign d_ready = mem_ready & (state_q == GNT_D);

endmodule : mem_arbiter
